// File: rtl/psa_pkg.sv
// Shared types and constants for the pattern search datapath.
package psa_pkg;

    localparam int ADDR_W = 8;
    localparam logic [ADDR_W-1:0] NOT_FOUND = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        ARM,
        CAPTURE,
        STALL,
        RELEASE,
        FINISH
    } state_t;

endpackage

// File: rtl/match_fifo.sv
// Show-ahead match address FIFO; the head is visible on rd_data_o while not empty.
module match_fifo
    import psa_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [ADDR_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       cnt_q;
    logic [ADDR_W-1:0] mem [DEPTH];
    logic              do_wr, do_rd;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_wr   = wr_en_i && !full_o;
    assign do_rd   = rd_en_i && !empty_o;

    // Masked when empty so the head reads 0 rather than stale storage.
    assign rd_data_o = empty_o ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/match_collector.sv
// Search sequencer: re-arms the engine after every hit and buffers match addresses.
// Optional watchdog on ARM/RELEASE waits is built when MATCH_TIMEOUT_EN is defined.
module match_collector
    import psa_pkg::*;
#(
    parameter int DEPTH = 16
`ifdef MATCH_TIMEOUT_EN
    , parameter int TIMEOUT = 1024
`endif
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] p_in,
    input  logic [ADDR_W-1:0] pl_in,
    input  logic [ADDR_W-1:0] b_in,
    input  logic [ADDR_W-1:0] bl_in,
    output logic [ADDR_W-1:0] p,
    output logic [ADDR_W-1:0] pl,
    output logic [ADDR_W-1:0] b,
    output logic [ADDR_W-1:0] bl,
    output logic              s_reset,
    output logic              s_activate,
    input  logic              s_done,
    input  logic [ADDR_W-1:0] s_found,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [7:0]        count,
    output logic              busy,
    output logic              complete,
    output logic              overflow,
    output logic              timeout
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] found_q, found_d;
    logic [ADDR_W-1:0] p_q, pl_q, b_q, bl_q;
    logic [7:0]        count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              push, flush, wd_hit;
    logic [ADDR_W-1:0] push_data;
    logic              fifo_full, fifo_empty;

    assign flush = (state_q == IDLE) && start;

    always_comb begin
        state_d   = state_q;
        found_d   = found_q;
        push      = 1'b0;
        push_data = s_found;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE:    if (start) state_d = RST;
            RST:     state_d = ARM;
            ARM: begin
                if (s_done)      state_d = CAPTURE;
                else if (wd_hit) state_d = FINISH;
            end
            CAPTURE: begin
                found_d = s_found;
                if (s_found == NOT_FOUND) begin
                    state_d = FINISH;
                end else if (fifo_full) begin
                    ovf_d   = 1'b1;
                    state_d = STALL;
                end else begin
                    push    = 1'b1;
                    state_d = RELEASE;
                end
            end
            STALL: begin
                push_data = found_q;
                if (!fifo_full) begin
                    push    = 1'b1;
                    state_d = RELEASE;
                end
            end
            // Waiting for s_done to fall keeps a held s_done from producing a second push.
            RELEASE: begin
                if (!s_done)     state_d = ARM;
                else if (wd_hit) state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) ovf_d = 1'b0;
    end

    always_comb begin
        count_d = count_q;
        if (flush)                        count_d = '0;
        else if (push && count_q != 8'hFF) count_d = count_q + 8'd1;
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            found_q <= '0;
            p_q     <= '0;
            pl_q    <= '0;
            b_q     <= '0;
            bl_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            found_q <= found_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (flush) begin
                p_q  <= p_in;
                pl_q <= pl_in;
                b_q  <= b_in;
                bl_q <= bl_in;
            end
        end
    end

`ifdef MATCH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q;
    logic            to_q;

    assign wd_hit  = ((state_q == ARM) || (state_q == RELEASE)) && (wd_q == WD_W'(TIMEOUT - 1));
    assign timeout = to_q;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            if (state_d != state_q)                           wd_q <= '0;
            else if ((state_q == ARM) || (state_q == RELEASE)) wd_q <= wd_q + 1'b1;
            if (flush)                                  to_q <= 1'b0;
            else if (wd_hit && (state_d == FINISH))     to_q <= 1'b1;
        end
    end
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    match_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i    (CLK100MHZ),
        .rst_i    (reset),
        .clr_i    (flush),
        .wr_en_i  (push),
        .wr_data_i(push_data),
        .rd_en_i  (rd_en),
        .rd_data_o(rd_data),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    assign p          = p_q;
    assign pl         = pl_q;
    assign b          = b_q;
    assign bl         = bl_q;
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign rd_valid   = !fifo_empty;
    assign s_reset    = (state_q == RST);
    assign s_activate = (state_q == ARM) || (state_q == CAPTURE);
    assign busy       = (state_q != IDLE);
    assign complete   = (state_q == FINISH);

endmodule

// File: tb/tb_match_collector.sv
// Scoreboard bench for match_collector with a behavioural search-engine model.
module tb_match_collector;
    import psa_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] p_in = '0, pl_in = '0, b_in = '0, bl_in = '0;
    logic [7:0] p, pl, b, bl;
    logic       s_reset, s_activate;
    logic       s_done = 1'b0;
    logic [7:0] s_found = '0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data, count;
    logic       rd_valid, busy, complete, overflow, timeout;

    int         n_chk = 0, n_fail = 0, cyc = 0;
    int         n_complete = 0, n_sreset = 0;
    logic [7:0] exp_q[$];
    logic [7:0] eng_list[$];
    int         eng_hold = 1;
    bit         eng_mute = 1'b0;

    match_collector #(
        .DEPTH(DEPTH)
`ifdef MATCH_TIMEOUT_EN
        , .TIMEOUT(8)
`endif
    ) dut (
        .CLK100MHZ(clk), .reset(reset), .start(start),
        .p_in(p_in), .pl_in(pl_in), .b_in(b_in), .bl_in(bl_in),
        .p(p), .pl(pl), .b(b), .bl(bl),
        .s_reset(s_reset), .s_activate(s_activate), .s_done(s_done), .s_found(s_found),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
        .busy(busy), .complete(complete), .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted pop against the scoreboard and counts pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (complete) n_complete++;
                if (s_reset)  n_sreset++;
                if (rd_en && rd_valid) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL sb_underflow: popped %0h with nothing expected", rd_data);
                    end else begin
                        chk("sb_rd_data", rd_data, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Engine model: answers one cycle after seeing s_activate, holds s_done for
    // eng_hold cycles minimum, and drops it once the collector stops activating.
    initial begin
        logic act, rs;
        int   idx, held;
        idx = 0;
        held = 0;
        forever begin
            @(negedge clk);
            act = s_activate;
            rs  = s_reset;
            @(posedge clk);
            #1;
            if (reset || rs) begin
                s_done = 1'b0;
                idx = 0;
                held = 0;
            end else if (s_done) begin
                held++;
                if (!act && held > eng_hold) begin
                    s_done = 1'b0;
                    idx++;
                end
            end else if (act && !eng_mute) begin
                s_done  = 1'b1;
                s_found = (idx < eng_list.size()) ? eng_list[idx] : NOT_FOUND;
                held    = 1;
            end
        end
    end

    task automatic do_start(input logic [7:0] pp, input logic [7:0] ppl,
                            input logic [7:0] bb, input logic [7:0] bbl, output int act_cyc);
        n_complete = 0;
        n_sreset   = 0;
        @(posedge clk);
        #1;
        p_in = pp; pl_in = ppl; b_in = bb; bl_in = bbl;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("s_reset_after_start", s_reset, 1);
        chk("b_latched", b, bb);
        chk("bl_latched", bl, bbl);
        chk("count_cleared", count, 0);
        @(posedge clk);
        #1;
        chk("s_activate_after_rst", s_activate, 1);
        chk("s_reset_one_cycle", s_reset, 0);
        act_cyc = cyc;
    endtask

    task automatic wait_complete(input int budget, output int at_cyc);
        bit hit;
        hit = 1'b0;
        at_cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (complete) begin
                hit = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
        if (!hit) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_complete: no complete pulse within %0d cycles", budget);
        end else begin
            chk("busy_during_complete", busy, 1);
            @(negedge clk);
            chk("complete_one_cycle", complete, 0);
            chk("busy_after_complete", busy, 0);
        end
    endtask

    task automatic pop_n(input int n);
        @(posedge clk);
        #1;
        rd_en = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (!rd_valid) break;
            rd_en = 1'b1;
        end
        rd_en = 1'b0;
        chk("sb_all_read", exp_q.size(), 0);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_s_reset"}, s_reset, 0);
        chk({tag, "_s_activate"}, s_activate, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_complete"}, complete, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_pbus"}, {p, pl, b, bl}, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
    endtask

    task automatic three_matches(input string tag);
        int a, c;
        eng_list = '{8'd3, 8'd9, 8'd15, 8'hFF};
        exp_q.push_back(8'd3);
        exp_q.push_back(8'd9);
        exp_q.push_back(8'd15);
        do_start(8'h40, 8'd4, 8'd0, 8'd20, a);
        wait_complete(200, c);
        chk({tag, "_count"}, count, 3);
        chk({tag, "_rd_valid"}, rd_valid, 1);
        chk({tag, "_head"}, rd_data, 8'd3);
        chk({tag, "_complete_pulses"}, n_complete, 1);
        chk({tag, "_s_reset_pulses"}, n_sreset, 1);
        drain();
    endtask

    initial begin
        int a, c;
        bit hit;

        #12;
        check_reset_outs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        three_matches("three");

        // No match: FF on the first step.
        eng_list = '{8'hFF};
        do_start(8'h01, 8'd2, 8'd30, 8'd5, a);
        wait_complete(50, c);
        chk("nomatch_latency", c - a, 3);
        chk("nomatch_rd_valid", rd_valid, 0);
        chk("nomatch_count", count, 0);

        // Full FIFO: six matches into four entries with no reads until stalled.
        eng_list = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hFF};
        for (int i = 0; i < 6; i++) exp_q.push_back(eng_list[i]);
        do_start(8'h02, 8'd3, 8'd0, 8'd100, a);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (overflow) begin hit = 1'b1; break; end
        end
        chk("full_overflow_set", hit, 1);
        chk("full_count_at_stall", count, 4);
        for (int i = 0; i < 3; i++) begin
            chk("full_stall_no_activate", s_activate, 0);
            chk("full_stall_busy", busy, 1);
            @(negedge clk);
        end
        pop_n(2);
        wait_complete(200, c);
        chk("full_count_final", count, 6);
        chk("full_overflow_sticky", overflow, 1);
        drain();

        // Held s_done: one assertion of five cycles must produce one push.
        eng_hold = 5;
        eng_list = '{8'h07, 8'hFF};
        exp_q.push_back(8'h07);
        do_start(8'h03, 8'd1, 8'd8, 8'd8, a);
        wait_complete(200, c);
        chk("held_count", count, 1);
        chk("held_overflow_cleared", overflow, 0);
        drain();
        eng_hold = 1;

        // Reset while waiting in RELEASE.
        eng_list = '{8'h21, 8'h22, 8'hFF};
        do_start(8'h04, 8'd2, 8'd10, 8'd10, a);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dut.state_q == RELEASE) begin hit = 1'b1; break; end
        end
        chk("midrst_reached_release", hit, 1);
        reset = 1'b1;
        #1;
        check_reset_outs("midrst");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        three_matches("restart");

`ifdef MATCH_TIMEOUT_EN
        eng_mute = 1'b1;
        do_start(8'h05, 8'd1, 8'd0, 8'd4, a);
        wait_complete(50, c);
        chk("wd_latency", c - a, 8);
        chk("wd_timeout", timeout, 1);
        chk("wd_count", count, 0);
        eng_mute = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
